// File: rtl/text_console_writer_if.sv
// Byte-in / tile-write-out bundle for text_console_writer.
// slave  : the console writer (consumes bytes, drives tile memory writes)
// master : the byte source / tile memory side (drives bytes, observes writes)
//   in_valid, in_data, in_ready : byte stream handshake
//   wr_en, wr_addr, wr_data     : tile memory write port
interface text_console_writer_if #(
    parameter int unsigned CODE_W = 8,
    parameter int unsigned ADDR_W = 12
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [CODE_W-1:0] wr_data;

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/text_console_writer.sv
// Converts a stream of ASCII bytes and control codes (CR, LF, BS, FF) into write cycles
// for the character tile memory, tracking a cursor on a COLS x ROWS grid. The screen is
// cleared after reset and on FF; each line feed clears the row it lands on.
// Ports:
//   px_clk   : pixel clock, the only clock
//   rst_n    : asynchronous active-low reset
//   bus      : byte handshake in, tile memory write strobe/address/data out
//   cur_col  : cursor column 0..COLS-1
//   cur_row  : cursor row 0..ROWS-1
//   busy     : high while a line or full-screen clear runs
module text_console_writer #(
    parameter int unsigned       COLS   = 80,
    parameter int unsigned       ROWS   = 30,
    parameter int unsigned       CODE_W = 8,
    parameter int unsigned       ADDR_W = 12,
    parameter logic [CODE_W-1:0] BLANK  = 8'h20
) (
    input  logic                  px_clk,
    input  logic                  rst_n,
    text_console_writer_if.slave  bus,
    output logic [6:0]            cur_col,
    output logic [4:0]            cur_row,
    output logic                  busy
);
    localparam logic [6:0]        LastCol   = 7'(COLS - 1);
    localparam logic [4:0]        LastRow   = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LastCell  = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LastInRow = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ColsA     = ADDR_W'(COLS);

    typedef enum logic [1:0] {StIdle, StClrLine, StClrAll} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [6:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CODE_W-1:0] wr_data_q, wr_data_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;

    logic [ADDR_W-1:0] row_base;
    logic [4:0]        row_next;
    logic              accept;

    assign row_base = ADDR_W'(row_q) * ColsA;
    assign row_next = (row_q == LastRow) ? 5'd0 : row_q + 5'd1;
    assign accept   = bus.in_valid && in_ready_q;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = row_base + ADDR_W'(col_q);
                        wr_data_d = CODE_W'(bus.in_data);
                        if (col_q == LastCol) begin
                            // Line wrap behaves exactly like CR+LF
                            col_d     = 7'd0;
                            row_d     = row_next;
                            clr_cnt_d = '0;
                            state_d   = StClrLine;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (bus.in_data)
                            8'h0D: col_d = 7'd0;
                            8'h0A: begin
                                row_d     = row_next;
                                clr_cnt_d = '0;
                                state_d   = StClrLine;
                            end
                            8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
                            8'h0C: begin
                                col_d     = 7'd0;
                                row_d     = 5'd0;
                                clr_cnt_d = '0;
                                state_d   = StClrAll;
                            end
                            default: ; // other control/high bytes are dropped
                        endcase
                    end
                end
            end
            StClrLine: begin
                // row_q already holds the new row
                wr_en_d   = 1'b1;
                wr_addr_d = row_base + clr_cnt_q;
                wr_data_d = BLANK;
                if (clr_cnt_q == LastInRow) begin
                    clr_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            StClrAll: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = BLANK;
                if (clr_cnt_q == LastCell) begin
                    clr_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                clr_cnt_d = '0;
                state_d   = StClrAll;
            end
        endcase

        // Registered from next state so they line up with state_q
        in_ready_d = (state_d == StIdle);
        busy_d     = (state_d == StClrLine) || (state_d == StClrAll);
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StClrAll;
            clr_cnt_q  <= '0;
            col_q      <= 7'd0;
            row_q      <= 5'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= BLANK;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign cur_col      = col_q;
    assign cur_row      = row_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int CELLS  = COLS * ROWS;
    localparam int LIMIT  = 5000;

    logic       px_clk = 1'b0;
    logic       rst_n  = 1'b0;
    logic [6:0] cur_col;
    logic [4:0] cur_row;
    logic       busy;

    text_console_writer_if #(.CODE_W(8), .ADDR_W(12)) bus ();

    text_console_writer #(
        .COLS(COLS), .ROWS(ROWS), .CODE_W(8), .ADDR_W(12), .BLANK(8'h20)
    ) dut (
        .px_clk  (px_clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cur_col (cur_col),
        .cur_row (cur_row),
        .busy    (busy)
    );

    always #5 px_clk = ~px_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic push_write(input int addr, input int data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic push_clear(input int base, input int n);
        for (int i = 0; i < n; i++) push_write(base + i, 32'h20);
    endtask

    // Every write the DUT makes must match the head of the scoreboard
    always @(negedge px_clk) begin
        if (rst_n && bus.wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 32'(bus.wr_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.wr_addr), e.addr);
                check("wr_data", 32'(bus.wr_data), e.data);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte was taken
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < LIMIT) begin
            @(negedge px_clk);
            n++;
        end
        check("rdy_timeout", 32'(n < LIMIT), 1);
        @(negedge px_clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (!bus.in_ready && n < limit) begin
            @(negedge px_clk);
            n++;
        end
        check("idle_timeout", 32'(n < limit), 1);
        #1;
        check("sb_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic check_cursor(input string tag, input int col, input int row);
        check({tag, "_col"}, 32'(cur_col), col);
        check({tag, "_row"}, 32'(cur_row), row);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // 1: reset values, then full clear after release
        #22;
        check("rst_wr_en", 32'(bus.wr_en), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_wr_data", 32'(bus.wr_data), 32'h20);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check_cursor("rst", 0, 0);
        push_clear(0, CELLS);
        @(negedge px_clk);
        rst_n = 1'b1;
        wait_idle(CELLS + 100);
        check("idle_busy", 32'(busy), 0);
        check_cursor("after_clr", 0, 0);

        // 2: back-to-back printables
        @(negedge px_clk);
        push_write(0, 8'h41);
        push_write(1, 8'h42);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h41;
        @(negedge px_clk);
        check("ab_first_en", 32'(bus.wr_en), 1);
        check("ab_first_addr", 32'(bus.wr_addr), 0);
        check("ab_rdy", 32'(bus.in_ready), 1);
        bus.in_data = 8'h42;
        @(negedge px_clk);
        bus.in_valid = 1'b0;
        check("ab_second_en", 32'(bus.wr_en), 1);
        check("ab_second_addr", 32'(bus.wr_addr), 1);
        check_cursor("ab", 2, 0);

        // 3: fill to column 79, then wrap with a line clear
        for (int i = 2; i < 79; i++) begin
            push_write(i, 8'h61 + (i % 26));
            send_byte(8'(8'h61 + (i % 26)));
        end
        check_cursor("col79", 79, 0);
        push_write(79, 8'h5A);
        push_clear(80, 80);
        send_byte(8'h5A);
        check_cursor("wrap", 0, 1);
        n = 0;
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge px_clk);
        end
        check("line_clr_len", 32'(n), 80);
        #1;
        check("sb_empty_wrap", 32'(exp_q.size()), 0);

        // 4: move to (5,3), then BS / CR / BS and dropped bytes
        push_clear(160, 80);
        send_byte(8'h0A);
        push_clear(240, 80);
        send_byte(8'h0A);
        for (int i = 0; i < 5; i++) begin
            push_write(240 + i, 8'h30 + i);
            send_byte(8'(8'h30 + i));
        end
        check_cursor("at_5_3", 5, 3);
        send_byte(8'h7F);
        send_byte(8'h01);
        send_byte(8'hFF);
        check_cursor("dropped", 5, 3);
        send_byte(8'h08);
        check_cursor("bs1", 4, 3);
        check("bs1_no_wr", 32'(bus.wr_en), 0);
        send_byte(8'h0D);
        check_cursor("cr", 0, 3);
        check("cr_no_wr", 32'(bus.wr_en), 0);
        send_byte(8'h08);
        check_cursor("bs_at0", 0, 3);
        check("bs0_no_wr", 32'(bus.wr_en), 0);

        // 5: row wrap on LF from row 29, then FF
        for (int r = 4; r < ROWS; r++) begin
            push_clear(r * COLS, COLS);
            send_byte(8'h0A);
        end
        for (int i = 0; i < 10; i++) begin
            push_write(29 * COLS + i, 8'h4B);
            send_byte(8'h4B);
        end
        check_cursor("at_10_29", 10, 29);
        push_clear(0, 80);
        send_byte(8'h0A);
        check_cursor("row_wrap", 10, 0);
        check("lf_busy", 32'(busy), 1);
        wait_idle(200);
        @(negedge px_clk);
        push_clear(0, CELLS);
        send_byte(8'h0C);
        check_cursor("ff", 0, 0);
        wait_idle(CELLS + 100);

        // 6: reset pulse mid-clear, byte held valid throughout
        @(negedge px_clk);
        push_clear(0, CELLS);
        send_byte(8'h0C);
        n = 0;
        while (!(bus.wr_en && bus.wr_addr == 12'd1000) && n < LIMIT) begin
            @(negedge px_clk);
            n++;
        end
        check("reach_1000", 32'(n < LIMIT), 1);
        check("clr_busy", 32'(busy), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h51;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_wr_en", 32'(bus.wr_en), 0);
        check("abort_in_ready", 32'(bus.in_ready), 0);
        exp_q.delete();
        push_clear(0, CELLS);
        @(negedge px_clk);
        @(negedge px_clk);
        check("rst_hold_rdy", 32'(bus.in_ready), 0);
        rst_n = 1'b1;
        wait_idle(CELLS + 100);
        push_write(0, 8'h51);
        @(negedge px_clk);
        bus.in_valid = 1'b0;
        #1;
        check("sb_empty_q", 32'(exp_q.size()), 0);
        check_cursor("after_q", 1, 0);

        repeat (3) @(negedge px_clk);
        check("sb_final", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
